branch_predictor_btb: RTL and testbench

- Parametrised dynamic branch predictor with branch target buffer (BTB).
- Replaces the constant not-taken fetch prediction bit that currently drives the IF/ID register.
- Looked up combinationally by the fetch stage every cycle. Trained by the resolved branch/jump leaving the MEM stage.
- Also provides saturating branch and mispredict statistics counters for the bench.

---
 rtl/branch_predictor_btb_if.sv | 34 +++
 rtl/branch_predictor_btb.sv | 100 ++++++++++
 tb/tb_branch_predictor_btb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup / resolve-update bundle for the branch predictor.
// master: fetch+MEM side; slave: the predictor (lookup, train, stats).
interface branch_predictor_btb_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  IF_PC;
    logic             PRED_TAKEN;
    logic [XLEN-1:0]  PRED_TARGET;
    logic             PRED_HIT;
    logic             UPD_VALID;
    logic [XLEN-1:0]  UPD_PC;
    logic             UPD_IS_JUMP;
    logic             UPD_TAKEN;
    logic [XLEN-1:0]  UPD_TARGET;
    logic             UPD_PRED_P;
    logic             MISPRED;
    logic [CNT_W-1:0] BR_COUNT;
    logic [CNT_W-1:0] MISS_COUNT;

    modport master (
        output IF_PC, UPD_VALID, UPD_PC, UPD_IS_JUMP,
        output UPD_TAKEN, UPD_TARGET, UPD_PRED_P,
        input  PRED_TAKEN, PRED_TARGET, PRED_HIT,
        input  MISPRED, BR_COUNT, MISS_COUNT
    );

    modport slave (
        input  IF_PC, UPD_VALID, UPD_PC, UPD_IS_JUMP,
        input  UPD_TAKEN, UPD_TARGET, UPD_PRED_P,
        output PRED_TAKEN, PRED_TARGET, PRED_HIT,
        output MISPRED, BR_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters and stats.
// Ports: CLK, RSTn (sync, active-low), EN (stall gate), bp (slave bundle).
module branch_predictor_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  EN,
    branch_predictor_btb_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] miss_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [CTR_W-1:0] ctr_inc;
    logic [CTR_W-1:0] ctr_dec;
    logic             mispred;
    logic             upd_fire;
    logic             unused_pc_bits;

    assign if_idx = bp.IF_PC[IDX_W+1:2];
    assign if_tag = bp.IF_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx  = bp.UPD_PC[IDX_W+1:2];
    assign u_tag  = bp.UPD_PC[IDX_W+TAG_W+1:IDX_W+2];

    // Byte offset and upper PC bits take no part in indexing or tagging.
    assign unused_pc_bits = ^{bp.IF_PC, bp.UPD_PC};

    // Lookup reads pre-edge state; a same-cycle update is not bypassed.
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bp.PRED_HIT    = if_hit;
    assign bp.PRED_TAKEN  = if_hit && ctr_q[if_idx][CTR_W-1];
    assign bp.PRED_TARGET = if_hit ? tgt_q[if_idx] : '0;

    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign mispred  = bp.UPD_VALID && (bp.UPD_PRED_P != bp.UPD_TAKEN);
    assign upd_fire = EN && bp.UPD_VALID;

    always_comb begin
        ctr_inc = ctr_q[u_idx];
        ctr_dec = ctr_q[u_idx];
        if (ctr_q[u_idx] != CTR_MAX) ctr_inc = ctr_q[u_idx] + CTR_W'(1);
        if (ctr_q[u_idx] != '0)      ctr_dec = ctr_q[u_idx] - CTR_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
            br_q   <= '0;
            miss_q <= '0;
        end else if (upd_fire) begin
            if (u_hit) begin
                if (bp.UPD_IS_JUMP) begin
                    ctr_q[u_idx] <= CTR_MAX;
                    tgt_q[u_idx] <= bp.UPD_TARGET;
                end else if (bp.UPD_TAKEN) begin
                    ctr_q[u_idx] <= ctr_inc;
                    tgt_q[u_idx] <= bp.UPD_TARGET;
                end else begin
                    ctr_q[u_idx] <= ctr_dec;
                end
            end else if (bp.UPD_TAKEN) begin
                // Only taken transfers earn a slot; evicts any alias.
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= bp.UPD_TARGET;
                ctr_q[u_idx]   <= bp.UPD_IS_JUMP ? CTR_MAX : CTR_WEAK;
            end
            if (br_q != CNT_MAX) br_q <= br_q + CNT_W'(1);
            if (mispred && (miss_q != CNT_MAX)) miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign bp.MISPRED    = mispred;
    assign bp.BR_COUNT   = br_q;
    assign bp.MISS_COUNT = miss_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb against a table model.
// Driver pushes expected lookup/stat values; negedge monitor compares.
module tb_branch_predictor_btb;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int SMAX    = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RSTn;
    logic EN;

    branch_predictor_btb_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bp ();

    branch_predictor_btb #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W),
        .CTR_W(CTR_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .EN(EN),
        .bp(bp)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          v;
        int unsigned tag;
        int          ctr;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        int          br;
        int          miss;
    } exp_t;

    ent_t tbl [ENTRIES];
    int   m_br;
    int   m_miss;
    bit   known = 0;
    exp_t sb [$];

    int tests = 0;
    int fails = 0;

    bit          p_rst = 0;
    bit          p_en  = 0;
    bit          p_uv  = 0;
    bit          p_j   = 0;
    bit          p_t   = 0;
    bit          p_pp  = 0;
    logic [31:0] p_upc = '0;
    logic [31:0] p_ut  = '0;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tag(input logic [31:0] pc);
        return (pc >> (2 + IDX_W)) % (1 << TAG_W);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Apply the edge that just happened to the model.
    task automatic model_edge();
        int i;
        if (!p_rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                tbl[k].v = 0;
                tbl[k].tag = 0;
                tbl[k].ctr = 0;
                tbl[k].tgt = '0;
            end
            m_br = 0;
            m_miss = 0;
            known = 1;
        end else if (known && p_en && p_uv) begin
            i = m_idx(p_upc);
            if (tbl[i].v && tbl[i].tag == m_tag(p_upc)) begin
                if (p_j) begin
                    tbl[i].ctr = CMAX;
                    tbl[i].tgt = p_ut;
                end else if (p_t) begin
                    tbl[i].ctr = imin(tbl[i].ctr + 1, CMAX);
                    tbl[i].tgt = p_ut;
                end else begin
                    tbl[i].ctr = imax(tbl[i].ctr - 1, 0);
                end
            end else if (p_t) begin
                tbl[i].v = 1;
                tbl[i].tag = m_tag(p_upc);
                tbl[i].tgt = p_ut;
                tbl[i].ctr = p_j ? CMAX : (1 << (CTR_W - 1));
            end
            m_br = imin(m_br + 1, SMAX);
            if (p_pp != p_t) m_miss = imin(m_miss + 1, SMAX);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [31:0] ipc,
                        input bit uv, input logic [31:0] upc, input bit j,
                        input bit t, input logic [31:0] ut, input bit pp);
        exp_t x;
        int   i;
        @(posedge CLK);
        #1;
        model_edge();
        RSTn = r;
        EN = e;
        bp.IF_PC = ipc;
        bp.UPD_VALID = uv;
        bp.UPD_PC = upc;
        bp.UPD_IS_JUMP = j;
        bp.UPD_TAKEN = t;
        bp.UPD_TARGET = ut;
        bp.UPD_PRED_P = pp;
        p_rst = r; p_en = e; p_uv = uv; p_upc = upc;
        p_j = j; p_t = t; p_ut = ut; p_pp = pp;
        if (known) begin
            i = m_idx(ipc);
            x.hit = tbl[i].v && tbl[i].tag == m_tag(ipc);
            x.taken = x.hit && (tbl[i].ctr >= (1 << (CTR_W - 1)));
            x.tgt = x.hit ? tbl[i].tgt : 32'h0;
            x.mis = uv && (pp != t);
            x.br = m_br;
            x.miss = m_miss;
            sb.push_back(x);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("pred_hit",   32'(bp.PRED_HIT),   32'(x.hit));
                chk("pred_taken", 32'(bp.PRED_TAKEN), 32'(x.taken));
                chk("pred_target", bp.PRED_TARGET,    x.tgt);
                chk("mispred",    32'(bp.MISPRED),    32'(x.mis));
                chk("br_count",   32'(bp.BR_COUNT),   32'(x.br));
                chk("miss_count", 32'(bp.MISS_COUNT), 32'(x.miss));
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          guard;
        RSTn = 1'b0;
        EN = 1'b1;
        bp.IF_PC = '0;
        bp.UPD_VALID = 1'b1;
        bp.UPD_PC = 32'h40;
        bp.UPD_IS_JUMP = 1'b0;
        bp.UPD_TAKEN = 1'b1;
        bp.UPD_TARGET = 32'h80;
        bp.UPD_PRED_P = 1'b0;

        // Reset held with live updates, then idle lookup.
        step(0, 1, 32'h100, 1, 32'h40, 0, 1, 32'h80, 0);
        step(0, 1, 32'h100, 1, 32'h40, 0, 1, 32'h80, 0);
        step(1, 1, 32'h100, 0, 32'h0,  0, 0, 32'h0,  0);
        step(1, 1, 32'h40,  0, 32'h0,  0, 0, 32'h0,  0);

        // Allocate then train the 0x40 entry.
        step(1, 1, 32'h40, 1, 32'h40, 0, 1, 32'h80, 0);
        step(1, 1, 32'h40, 0, 32'h0,  0, 0, 32'h0,  0);
        repeat (3) step(1, 1, 32'h40, 1, 32'h40, 0, 0, 32'h0, 1);
        step(1, 1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (4) step(1, 1, 32'h40, 1, 32'h40, 0, 1, 32'h80, 0);
        step(1, 1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 0);

        // Not-taken miss must not allocate.
        step(1, 1, 32'h200, 1, 32'h200, 0, 0, 32'h300, 0);
        step(1, 1, 32'h200, 0, 32'h0,   0, 0, 32'h0,   0);

        // Jump allocate, then conflicting branch evicts it.
        step(1, 1, 32'h44,  1, 32'h44,  1, 1, 32'h1000, 0);
        step(1, 1, 32'h44,  1, 32'h444, 0, 1, 32'h20,   1);
        step(1, 1, 32'h44,  0, 32'h0,   0, 0, 32'h0,    0);
        step(1, 1, 32'h444, 0, 32'h0,   0, 0, 32'h0,    0);

        // Same-cycle lookup/update, then with EN low.
        step(1, 1, 32'h40, 1, 32'h40, 0, 0, 32'h0,  0);
        step(1, 1, 32'h40, 1, 32'h40, 0, 0, 32'h0,  1);
        step(1, 0, 32'h40, 1, 32'h40, 0, 0, 32'h0,  1);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h99, 0);
        step(1, 1, 32'h40, 0, 32'h0,  0, 0, 32'h0,  0);

        // Statistics saturation from a clean reset.
        step(0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 20; k++) begin
            a = 32'(k) << 2;
            step(1, 1, a, 1, a, 0, k[0], 32'h500 + a, ~k[0]);
        end
        step(1, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);

        // Randomised traffic over a small PC space to force hits/aliases.
        step(0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 800; k++) begin
            a = 32'($urandom_range(0, 95) << 2) | 32'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) == 1) ? a
                : (32'($urandom_range(0, 95) << 2) | 32'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) b = $urandom;
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0),
                 b, ($urandom_range(0, 9) < 6), a,
                 ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
                 $urandom, $urandom_range(0, 1));
        end
        step(1, 1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge CLK);
            guard++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
